// File: rtl/id_ex_skid_reg_if.sv
// Handshake and payload bundle between the decode stage, the ID/EX skid register and the execute stage.
// The slave modport is the register's view. The master modport is the view of the decode/execute side.
interface id_ex_skid_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_W       = 2,
  parameter int MEM_W      = 3,
  parameter int ALUOP_W    = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WB_W-1:0]       wb_in;
  logic [MEM_W-1:0]      mem_in;
  logic [ALUOP_W+1:0]    ex_in;
  logic [DATA_W-1:0]     pc_in;
  logic [DATA_W-1:0]     rs_data_in;
  logic [DATA_W-1:0]     rt_data_in;
  logic [DATA_W-1:0]     imm_in;
  logic [REG_ADDR_W-1:0] rt_addr_in;
  logic [REG_ADDR_W-1:0] rd_addr_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [WB_W-1:0]       wb_out;
  logic [MEM_W-1:0]      mem_out;
  logic                  alu_src;
  logic [ALUOP_W-1:0]    alu_op;
  logic                  reg_dst;
  logic [DATA_W-1:0]     pc_out;
  logic [DATA_W-1:0]     rs_data_out;
  logic [DATA_W-1:0]     rt_data_out;
  logic [DATA_W-1:0]     imm_out;
  logic [REG_ADDR_W-1:0] rt_addr_out;
  logic [REG_ADDR_W-1:0] rd_addr_out;

  modport slave (
    input  in_valid, wb_in, mem_in, ex_in, pc_in, rs_data_in, rt_data_in, imm_in,
           rt_addr_in, rd_addr_in, out_ready,
    output in_ready, out_valid, wb_out, mem_out, alu_src, alu_op, reg_dst, pc_out,
           rs_data_out, rt_data_out, imm_out, rt_addr_out, rd_addr_out
  );

  modport master (
    output in_valid, wb_in, mem_in, ex_in, pc_in, rs_data_in, rt_data_in, imm_in,
           rt_addr_in, rd_addr_in, out_ready,
    input  in_ready, out_valid, wb_out, mem_out, alu_src, alu_op, reg_dst, pc_out,
           rs_data_out, rt_data_out, imm_out, rt_addr_out, rd_addr_out
  );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register built as a 2-entry skid buffer with flush and a saturating backpressure counter.
// Every output is driven straight from a register bit. in_ready depends only on held state.
module id_ex_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_W       = 2,
  parameter int MEM_W      = 3,
  parameter int ALUOP_W    = 2,
  parameter int CNT_W      = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  id_ex_skid_reg_if.slave    bus,
  output logic [CNT_W-1:0]   o_stall_count
);

  localparam int CTL_W = WB_W + MEM_W + ALUOP_W + 2;
  localparam int DAT_W = 4 * DATA_W + 2 * REG_ADDR_W;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_main_v;
  logic             r_skid_v;
  logic [CTL_W-1:0] r_main_ctl;
  logic [CTL_W-1:0] r_skid_ctl;
  logic [DAT_W-1:0] r_main_dat;
  logic [DAT_W-1:0] r_skid_dat;
  logic [CNT_W-1:0] r_stall;

  logic [CTL_W-1:0] w_in_ctl;
  logic [DAT_W-1:0] w_in_dat;
  logic             w_accept;
  logic             w_drain;
  logic [1:0]       w_state;

  assign w_in_ctl = {bus.wb_in, bus.mem_in, bus.ex_in};
  assign w_in_dat = {bus.pc_in, bus.rs_data_in, bus.rt_data_in, bus.imm_in,
                     bus.rt_addr_in, bus.rd_addr_in};
  assign w_accept = bus.in_valid & ~r_skid_v & ~i_flush;
  assign w_drain  = r_main_v & bus.out_ready;
  assign w_state  = {r_main_v, r_skid_v};

  // The main entry's control field is cleared whenever main goes invalid, so bubbles show zero control
  // while the data fields keep their last value.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_main_ctl <= {CTL_W{1'b0}};
      r_skid_ctl <= {CTL_W{1'b0}};
      r_main_dat <= {DAT_W{1'b0}};
      r_skid_dat <= {DAT_W{1'b0}};
    end else if (i_flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_main_ctl <= {CTL_W{1'b0}};
      r_skid_ctl <= {CTL_W{1'b0}};
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_v   <= 1'b1;
            r_main_ctl <= w_in_ctl;
            r_main_dat <= w_in_dat;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            r_main_ctl <= w_in_ctl;
            r_main_dat <= w_in_dat;
          end else if (w_accept) begin
            r_skid_v   <= 1'b1;
            r_skid_ctl <= w_in_ctl;
            r_skid_dat <= w_in_dat;
          end else if (w_drain) begin
            r_main_v   <= 1'b0;
            r_main_ctl <= {CTL_W{1'b0}};
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            r_main_ctl <= r_skid_ctl;
            r_main_dat <= r_skid_dat;
            r_skid_v   <= 1'b0;
            r_skid_ctl <= {CTL_W{1'b0}};
          end
        end
        default: begin
          r_main_v   <= 1'b0;
          r_skid_v   <= 1'b0;
          r_main_ctl <= {CTL_W{1'b0}};
          r_skid_ctl <= {CTL_W{1'b0}};
        end
      endcase
    end
  end

  // A flush cycle is not counted as a stall cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall <= {CNT_W{1'b0}};
    end else if (!i_flush && r_main_v && !bus.out_ready && (r_stall != CNT_MAX)) begin
      r_stall <= r_stall + CNT_ONE;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign bus.in_ready  = ~r_skid_v;
  assign bus.out_valid = r_main_v;
  assign {bus.wb_out, bus.mem_out, bus.reg_dst, bus.alu_op, bus.alu_src} = r_main_ctl;
  assign {bus.pc_out, bus.rs_data_out, bus.rt_data_out, bus.imm_out,
          bus.rt_addr_out, bus.rd_addr_out} = r_main_dat;
  assign o_stall_count = r_stall;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg with a queue scoreboard tracking the accepted payloads.
// A second instance with a 3-bit counter shares the stimulus so that saturation can be checked.
module tb_id_ex_skid_reg;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  rta;
    logic [4:0]  rda;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] stall1;
  logic [2:0]  stall2;

  int   n_cmp = 0;
  int   n_err = 0;
  pl_t  sb[$];
  pl_t  cur_in;

  always #5 clk = ~clk;

  id_ex_skid_reg_if bus1 ();
  id_ex_skid_reg_if bus2 ();

  assign bus2.in_valid   = bus1.in_valid;
  assign bus2.out_ready  = bus1.out_ready;
  assign bus2.wb_in      = bus1.wb_in;
  assign bus2.mem_in     = bus1.mem_in;
  assign bus2.ex_in      = bus1.ex_in;
  assign bus2.pc_in      = bus1.pc_in;
  assign bus2.rs_data_in = bus1.rs_data_in;
  assign bus2.rt_data_in = bus1.rt_data_in;
  assign bus2.imm_in     = bus1.imm_in;
  assign bus2.rt_addr_in = bus1.rt_addr_in;
  assign bus2.rd_addr_in = bus1.rd_addr_in;

  id_ex_skid_reg dut1 (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .bus(bus1), .o_stall_count(stall1)
  );

  id_ex_skid_reg #(.CNT_W(3)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .bus(bus2), .o_stall_count(stall2)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] pc, input logic [3:0] ex);
    pl_t p;
    p.wb  = pc[5:4] | 2'b01;
    p.mem = pc[8:6] ^ 3'b101;
    p.ex  = ex;
    p.pc  = pc;
    p.rs  = $urandom;
    p.rt  = $urandom;
    p.imm = $urandom;
    p.rta = pc[6:2];
    p.rda = ~pc[6:2];
    return p;
  endfunction

  function automatic pl_t observed();
    pl_t o;
    o.wb  = bus1.wb_out;
    o.mem = bus1.mem_out;
    o.ex  = {bus1.reg_dst, bus1.alu_op, bus1.alu_src};
    o.pc  = bus1.pc_out;
    o.rs  = bus1.rs_data_out;
    o.rt  = bus1.rt_data_out;
    o.imm = bus1.imm_out;
    o.rta = bus1.rt_addr_out;
    o.rda = bus1.rd_addr_out;
    return o;
  endfunction

  task automatic drive(input pl_t p, input logic v);
    cur_in           = p;
    bus1.in_valid    = v;
    bus1.wb_in       = p.wb;
    bus1.mem_in      = p.mem;
    bus1.ex_in       = p.ex;
    bus1.pc_in       = p.pc;
    bus1.rs_data_in  = p.rs;
    bus1.rt_data_in  = p.rt;
    bus1.imm_in      = p.imm;
    bus1.rt_addr_in  = p.rta;
    bus1.rd_addr_in  = p.rda;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the queue depth models valid/ready, and the front entry is the expected output.
  always @(negedge clk) begin
    bit  m_vld;
    bit  m_rdy;
    pl_t e;
    if (rst) begin
      sb.delete();
    end else begin
      m_vld = (sb.size() > 0);
      m_rdy = (sb.size() < 2);
      chk("sb_out_valid", bus1.out_valid, m_vld);
      chk("sb_in_ready", bus1.in_ready, m_rdy);
      if (!m_vld)
        chk("sb_bubble_ctl", {bus1.wb_out, bus1.mem_out, bus1.reg_dst, bus1.alu_op, bus1.alu_src}, 0);
      if (flush) begin
        sb.delete();
      end else begin
        if (m_vld && bus1.out_ready) begin
          e = sb.pop_front();
          chk("sb_payload", observed(), e);
        end
        if (bus1.in_valid && m_rdy) sb.push_back(cur_in);
      end
    end
  end

  initial begin
    pl_t pa, pb, pc, pd, pe, pf, ph, pi, pj;
    pl_t pk[9];

    drive(mk(32'h0, 4'b0000), 1'b0);
    bus1.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", bus1.out_valid, 1'b0);
    chk("rst_in_ready", bus1.in_ready, 1'b1);
    chk("rst_pc_out", bus1.pc_out, 32'h0);
    chk("rst_stall", stall1, 16'd0);
    step();
    chk("post_rst_in_ready", bus1.in_ready, 1'b1);

    // Single payload, 1-cycle latency and field split of ex.
    pa = mk(32'h40, 4'b1011);
    drive(pa, 1'b1);
    bus1.out_ready = 1'b1;
    step();
    drive(pa, 1'b0);
    chk("single_valid", bus1.out_valid, 1'b1);
    chk("single_alu_src", bus1.alu_src, 1'b1);
    chk("single_alu_op", bus1.alu_op, 2'b01);
    chk("single_reg_dst", bus1.reg_dst, 1'b1);
    chk("single_pc", bus1.pc_out, 32'h40);
    step();
    chk("single_drop", bus1.out_valid, 1'b0);
    chk("single_bubble_op", bus1.alu_op, 2'b00);

    // Three payloads under backpressure, then release.
    pa = mk(32'h100, 4'b0010);
    pb = mk(32'h104, 4'b0100);
    pc = mk(32'h108, 4'b1001);
    bus1.out_ready = 1'b0;
    drive(pa, 1'b1);
    step();
    drive(pb, 1'b1);
    step();
    chk("full_in_ready", bus1.in_ready, 1'b0);
    chk("full_main_pc", bus1.pc_out, pa.pc);
    drive(pc, 1'b1);
    step();
    chk("full_c_blocked", bus1.in_ready, 1'b0);
    chk("full_hold_pc", bus1.pc_out, pa.pc);
    chk("full_stall", stall1, 16'd2);
    bus1.out_ready = 1'b1;
    step();
    chk("rel_b_pc", bus1.pc_out, pb.pc);
    chk("rel_in_ready", bus1.in_ready, 1'b1);
    step();
    drive(pc, 1'b0);
    chk("rel_c_pc", bus1.pc_out, pc.pc);
    step();
    chk("rel_empty", bus1.out_valid, 1'b0);

    // Stall counting and saturation of the narrow counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus1.out_ready = 1'b0;
    pd = mk(32'h200, 4'b0110);
    drive(pd, 1'b1);
    step();
    drive(pd, 1'b0);
    repeat (5) step();
    chk("stall5_w16", stall1, 16'd5);
    chk("stall5_w3", stall2, 3'd5);
    repeat (5) step();
    chk("stall10_w16", stall1, 16'd10);
    chk("stall10_w3_sat", stall2, 3'd7);

    // Flush while full with a payload presented in the same cycle.
    pe = mk(32'h300, 4'b1111);
    pf = mk(32'h304, 4'b1101);
    drive(pe, 1'b1);
    step();
    drive(pf, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(pf, 1'b0);
    chk("flush_valid", bus1.out_valid, 1'b0);
    chk("flush_in_ready", bus1.in_ready, 1'b1);
    chk("flush_ctl", {bus1.wb_out, bus1.mem_out, bus1.reg_dst, bus1.alu_op, bus1.alu_src}, 0);
    chk("flush_pc_hold", bus1.pc_out, pd.pc);
    chk("flush_stall", stall1, 16'd11);
    bus1.out_ready = 1'b1;
    step();
    chk("flush_dropped", bus1.out_valid, 1'b0);

    // Reset while full, then a fresh payload.
    bus1.out_ready = 1'b0;
    ph = mk(32'h400, 4'b0011);
    pi = mk(32'h404, 4'b0101);
    drive(ph, 1'b1);
    step();
    drive(pi, 1'b1);
    step();
    drive(pi, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstf_valid", bus1.out_valid, 1'b0);
    chk("rstf_pc", bus1.pc_out, 32'h0);
    chk("rstf_rs", bus1.rs_data_out, 32'h0);
    chk("rstf_ctl", {bus1.wb_out, bus1.mem_out, bus1.reg_dst, bus1.alu_op, bus1.alu_src}, 0);
    chk("rstf_stall", stall1, 16'd0);
    chk("rstf_in_ready", bus1.in_ready, 1'b1);
    pj = mk(32'h500, 4'b1010);
    drive(pj, 1'b1);
    bus1.out_ready = 1'b1;
    step();
    drive(pj, 1'b0);
    chk("rstf_lat_valid", bus1.out_valid, 1'b1);
    chk("rstf_lat_pc", bus1.pc_out, pj.pc);
    step();

    // Back-to-back accept and drain.
    for (int k = 0; k < 9; k++) pk[k] = mk(32'h600 + 32'(k) * 32'd4, 4'(k));
    drive(pk[0], 1'b1);
    step();
    for (int k = 1; k < 9; k++) begin
      drive(pk[k], 1'b1);
      step();
      chk("b2b_valid", bus1.out_valid, 1'b1);
      chk("b2b_in_ready", bus1.in_ready, 1'b1);
      chk("b2b_pc", bus1.pc_out, pk[k].pc);
    end
    drive(pk[8], 1'b0);
    step();
    chk("b2b_drain", bus1.out_valid, 1'b0);
    step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
